temp_alert_monitor: RTL and testbench

- Fabric block directly upstream of the MSS `GPIO_IN` alert inputs.
- Consumes signed temperature samples read from the I2C temperature sensor by the CoreI2C/MSS path and checks them against programmable high/low thresholds with hysteresis and N-sample debounce.
- Drives a level alert, a sticky interrupt with acknowledge, and last/peak temperature registers for firmware.

---
 rtl/temp_alert_pkg.sv | 23 ++
 rtl/temp_alert_fsm.sv | 91 +++++++++
 rtl/temp_alert_monitor.sv | 164 ++++++++++++++++
 tb/tb_temp_alert_monitor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_alert_pkg.sv
// Shared types and constants for temp_alert_monitor and its debounce FSM.
package temp_alert_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_PEND_HI = 2'd1,
      ST_ALERT   = 2'd2,
      ST_PEND_LO = 2'd3
   } alert_state_e;

   localparam int DEF_DATA_W = 12;
   localparam int CNT_W      = 4;

   // Most-negative two's complement value of a w-bit sample, right-aligned in 32 bits.
   function automatic logic [31:0] min_temp(input int w);
      return 32'd1 << (w - 1);
   endfunction

   function automatic logic state_is_alert(input alert_state_e s);
      return (s == ST_ALERT) || (s == ST_PEND_LO);
   endfunction

endpackage

// File: rtl/temp_alert_fsm.sv
// Hot/cool debounce state machine with hysteresis; pulses toggle on every
// change of the alert level it implies.
module temp_alert_fsm
   import temp_alert_pkg::*;
#(
   parameter int DEBOUNCE = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         strobe,
   input  logic         hot,
   input  logic         cool,
   output alert_state_e state,
   output logic         toggle
);

   localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE);

   alert_state_e     state_r;
   alert_state_e     state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W-1:0] cnt_inc_s;

   assign cnt_inc_s = cnt_r + 4'd1;

   // Next state: only the flag that could change the current level is examined.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (strobe) begin
         case (state_r)
            ST_NORMAL: begin
               if (hot) begin
                  cnt_nxt_s   = 4'd1;
                  state_nxt_s = (DEB_C == 4'd1) ? ST_ALERT : ST_PEND_HI;
               end else begin
                  state_nxt_s = ST_NORMAL;
               end
            end
            ST_PEND_HI: begin
               if (hot) begin
                  cnt_nxt_s   = cnt_inc_s;
                  state_nxt_s = (cnt_inc_s >= DEB_C) ? ST_ALERT : ST_PEND_HI;
               end else begin
                  cnt_nxt_s   = 4'd0;
                  state_nxt_s = ST_NORMAL;
               end
            end
            ST_ALERT: begin
               if (cool) begin
                  cnt_nxt_s   = 4'd1;
                  state_nxt_s = (DEB_C == 4'd1) ? ST_NORMAL : ST_PEND_LO;
               end else begin
                  state_nxt_s = ST_ALERT;
               end
            end
            ST_PEND_LO: begin
               if (cool) begin
                  cnt_nxt_s   = cnt_inc_s;
                  state_nxt_s = (cnt_inc_s >= DEB_C) ? ST_NORMAL : ST_PEND_LO;
               end else begin
                  cnt_nxt_s   = 4'd0;
                  state_nxt_s = ST_ALERT;
               end
            end
            default: begin
               cnt_nxt_s   = 4'd0;
               state_nxt_s = ST_NORMAL;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and debounce count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_NORMAL;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   assign state  = state_r;
   assign toggle = state_is_alert(state_nxt_s) ^ state_is_alert(state_r);

endmodule

// File: rtl/temp_alert_monitor.sv
// Temperature threshold monitor: sample handshake, debounced alert, sticky IRQ,
// last/peak registers. Stale-sample watchdog built when TEMP_ALERT_WATCHDOG_EN is defined.
module temp_alert_monitor
   import temp_alert_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEBOUNCE  = 3,
   parameter int WD_CYCLES = 50_000_000
) (
   input  logic              FAB_CCC_GL0,
   input  logic              FAB_RESET,
   input  logic              SAMPLE_VALID,
   input  logic [DATA_W-1:0] SAMPLE_DATA,
   output logic              SAMPLE_READY,
   input  logic [DATA_W-1:0] THRESH_HI,
   input  logic [DATA_W-1:0] THRESH_LO,
   input  logic              IRQ_ACK,
   input  logic              PEAK_CLR,
   output logic              ALERT,
   output logic              ALERT_IRQ,
   output logic [DATA_W-1:0] LAST_TEMP,
   output logic [DATA_W-1:0] MAX_TEMP,
   output logic              STALE
);

   localparam logic [31:0]       MIN_TEMP_W = min_temp(DATA_W);
   localparam logic [DATA_W-1:0] MIN_TEMP_C = MIN_TEMP_W[DATA_W-1:0];

   logic              accept_s;
   logic              busy_r;
   logic [DATA_W-1:0] s1_data_r;
   logic              s1_hot_r;
   logic              s1_cool_r;
   logic [DATA_W-1:0] last_r;
   logic [DATA_W-1:0] max_r;
   logic [DATA_W-1:0] max_nxt_s;
   logic              alert_r;
   logic              alert_nxt_s;
   logic              irq_r;
   logic              irq_set_s;
   alert_state_e      fsm_state_s;
   logic              fsm_toggle_s;
   logic              fsm_alert_nxt_s;

   // busy doubles as the stage-2 strobe: it is high exactly in the cycle after an accept.
   assign accept_s     = SAMPLE_VALID & ~busy_r;
   assign SAMPLE_READY = ~busy_r;

   // Stage 1: capture the sample and compare against the thresholds present on the accept edge.
   always_ff @(posedge FAB_CCC_GL0) begin
      if (FAB_RESET) begin
         busy_r    <= 1'b0;
         s1_data_r <= {DATA_W{1'b0}};
         s1_hot_r  <= 1'b0;
         s1_cool_r <= 1'b0;
      end else begin
         busy_r <= accept_s;
         if (accept_s) begin
            s1_data_r <= SAMPLE_DATA;
            s1_hot_r  <= $signed(SAMPLE_DATA) >= $signed(THRESH_HI);
            s1_cool_r <= $signed(SAMPLE_DATA) < $signed(THRESH_LO);
         end
      end
   end

   temp_alert_fsm #(
      .DEBOUNCE (DEBOUNCE)
   ) u_fsm (
      .clk    (FAB_CCC_GL0),
      .rst    (FAB_RESET),
      .strobe (busy_r),
      .hot    (s1_hot_r),
      .cool   (s1_cool_r),
      .state  (fsm_state_s),
      .toggle (fsm_toggle_s)
   );

   assign fsm_alert_nxt_s = state_is_alert(fsm_state_s) ^ fsm_toggle_s;

`ifdef TEMP_ALERT_WATCHDOG_EN
   localparam int              WD_W      = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST_C = WD_W'(WD_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt_r;
   logic            wd_hit_s;
   logic            stale_r;
   logic            stale_nxt_s;

   assign wd_hit_s = (wd_cnt_r == WD_LAST_C) & ~accept_s;

   // A sample reaching stage 2 clears STALE; otherwise the timeout sets it.
   always_comb begin
      stale_nxt_s = stale_r;
      if (busy_r) begin
         stale_nxt_s = 1'b0;
      end else if (wd_hit_s) begin
         stale_nxt_s = 1'b1;
      end else begin
         stale_nxt_s = stale_r;
      end
   end

   // Timer saturates at its terminal count so a long silence cannot wrap back to fresh.
   always_ff @(posedge FAB_CCC_GL0) begin
      if (FAB_RESET) begin
         wd_cnt_r <= {WD_W{1'b0}};
         stale_r  <= 1'b0;
      end else begin
         stale_r <= stale_nxt_s;
         if (accept_s) begin
            wd_cnt_r <= {WD_W{1'b0}};
         end else if (wd_cnt_r != WD_LAST_C) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1'b1);
         end
      end
   end

   // While stale, ALERT is forced high; leaving stale raises an IRQ only if ALERT drops.
   assign alert_nxt_s = stale_nxt_s | fsm_alert_nxt_s;
   assign irq_set_s   = (stale_nxt_s & ~stale_r)
                      | (~stale_r & ~stale_nxt_s & fsm_toggle_s)
                      | (stale_r & ~stale_nxt_s & ~fsm_alert_nxt_s);
   assign STALE       = stale_r;
`else
   assign alert_nxt_s = fsm_alert_nxt_s;
   assign irq_set_s   = fsm_toggle_s;
   assign STALE       = 1'b0;
`endif

   // Peak tracker; a clear coinciding with a stage-2 sample takes that sample.
   always_comb begin
      max_nxt_s = max_r;
      if (PEAK_CLR) begin
         max_nxt_s = busy_r ? s1_data_r : MIN_TEMP_C;
      end else if (busy_r && ($signed(s1_data_r) > $signed(max_r))) begin
         max_nxt_s = s1_data_r;
      end else begin
         max_nxt_s = max_r;
      end
   end

   // Stage 2 output registers; a set beats a simultaneous acknowledge.
   always_ff @(posedge FAB_CCC_GL0) begin
      if (FAB_RESET) begin
         alert_r <= 1'b0;
         irq_r   <= 1'b0;
         last_r  <= {DATA_W{1'b0}};
         max_r   <= MIN_TEMP_C;
      end else begin
         alert_r <= alert_nxt_s;
         irq_r   <= irq_set_s | (irq_r & ~IRQ_ACK);
         max_r   <= max_nxt_s;
         if (busy_r) begin
            last_r <= s1_data_r;
         end
      end
   end

   assign ALERT     = alert_r;
   assign ALERT_IRQ = irq_r;
   assign LAST_TEMP = last_r;
   assign MAX_TEMP  = max_r;

endmodule

// File: tb/tb_temp_alert_monitor.sv
// Scoreboard bench for temp_alert_monitor; exercises the watchdog when
// TEMP_ALERT_WATCHDOG_EN is defined, otherwise checks STALE stays low.
module tb_temp_alert_monitor;

   localparam int DEB = 3;
   localparam int WD  = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [11:0] data;
   logic        ready;
   logic [11:0] thr_hi;
   logic [11:0] thr_lo;
   logic        irq_ack;
   logic        peak_clr;
   logic        alert;
   logic        alert_irq;
   logic [11:0] last_temp;
   logic [11:0] max_temp;
   logic        stale;

   always #5 clk = ~clk;

   temp_alert_monitor #(
      .DATA_W    (12),
      .DEBOUNCE  (DEB),
      .WD_CYCLES (WD)
   ) dut (
      .FAB_CCC_GL0  (clk),
      .FAB_RESET    (rst),
      .SAMPLE_VALID (valid),
      .SAMPLE_DATA  (data),
      .SAMPLE_READY (ready),
      .THRESH_HI    (thr_hi),
      .THRESH_LO    (thr_lo),
      .IRQ_ACK      (irq_ack),
      .PEAK_CLR     (peak_clr),
      .ALERT        (alert),
      .ALERT_IRQ    (alert_irq),
      .LAST_TEMP    (last_temp),
      .MAX_TEMP     (max_temp),
      .STALE        (stale)
   );

   typedef struct {
      logic        alert;
      logic        irq;
      logic [11:0] last;
      logic [11:0] max;
      logic        stale;
   } exp_t;

   exp_t exp_q[$];

   int checks   = 0;
   int failures = 0;

   // Reference model: 0 NORMAL, 1 PEND_HI, 2 ALERT, 3 PEND_LO
   int          m_state;
   int          m_cnt;
   logic        m_alert;
   logic        m_irq;
   logic        m_stale;
   logic [11:0] m_last;
   logic [11:0] m_max;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_state = 0;
      m_cnt   = 0;
      m_alert = 1'b0;
      m_irq   = 1'b0;
      m_stale = 1'b0;
      m_last  = 12'h000;
      m_max   = 12'h800;
   endfunction

   function automatic void model_sample(input logic [11:0] d, input logic ack, input logic pclr);
      logic hot;
      logic cool;
      logic prev;
      hot  = $signed(d) >= $signed(thr_hi);
      cool = $signed(d) < $signed(thr_lo);
      case (m_state)
         0: if (hot) begin m_cnt = 1; m_state = (DEB == 1) ? 2 : 1; end
         1: if (hot) begin m_cnt++; if (m_cnt >= DEB) m_state = 2; end
            else begin m_cnt = 0; m_state = 0; end
         2: if (cool) begin m_cnt = 1; m_state = (DEB == 1) ? 0 : 3; end
         3: if (cool) begin m_cnt++; if (m_cnt >= DEB) m_state = 0; end
            else begin m_cnt = 0; m_state = 2; end
         default: m_state = 0;
      endcase
      prev    = m_alert;
      m_stale = 1'b0;
      m_alert = (m_state >= 2);
      m_irq   = (m_alert != prev) | (m_irq & ~ack);
      m_last  = d;
      if (pclr) m_max = d;
      else if ($signed(d) > $signed(m_max)) m_max = d;
   endfunction

   task automatic do_reset();
      rst      = 1'b1;
      valid    = 1'b1;     // offered during reset: must be ignored
      data     = 12'h7FF;
      irq_ack  = 1'b0;
      peak_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b0;
      valid = 1'b0;
      model_reset();
   endtask

   // Offer one sample; optionally pulse IRQ_ACK / PEAK_CLR on its stage-2 edge.
   task automatic send(input logic [11:0] d, input logic ack2 = 1'b0, input logic pclr2 = 1'b0);
      exp_t e;
      chk("ready_idle", 32'(ready), 32'd1);
      valid = 1'b1;
      data  = d;
      @(posedge clk);
      #1;
      valid = 1'b0;
      model_sample(d, ack2, pclr2);
      exp_q.push_back('{alert: m_alert, irq: m_irq, last: m_last, max: m_max, stale: m_stale});
      chk("ready_busy", 32'(ready), 32'd0);
      irq_ack  = ack2;
      peak_clr = pclr2;
      @(posedge clk);
      #1;
      irq_ack  = 1'b0;
      peak_clr = 1'b0;
      e = exp_q.pop_front();
      chk("alert", 32'(alert), 32'(e.alert));
      chk("alert_irq", 32'(alert_irq), 32'(e.irq));
      chk("last_temp", 32'(last_temp), 32'(e.last));
      chk("max_temp", 32'(max_temp), 32'(e.max));
      chk("stale", 32'(stale), 32'(e.stale));
      chk("ready_again", 32'(ready), 32'd1);
   endtask

   task automatic ack_pulse();
      irq_ack = 1'b1;
      @(posedge clk);
      #1;
      irq_ack = 1'b0;
      m_irq   = 1'b0;
      chk("irq_ack_only", 32'(alert_irq), 32'(m_irq));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int acc;
      int n;
      thr_hi = 12'h500;
      thr_lo = 12'h4B0;
      do_reset();

      chk("rst_alert", 32'(alert), 32'd0);
      chk("rst_irq", 32'(alert_irq), 32'd0);
      chk("rst_last", 32'(last_temp), 32'h000);
      chk("rst_max", 32'(max_temp), 32'h800);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_stale", 32'(stale), 32'd0);

      // threshold crossing (HI is inclusive)
      send(12'h500);
      send(12'h510);
      chk("cross_pre", 32'(alert), 32'd0);
      send(12'h520);
      chk("cross_alert", 32'(alert), 32'd1);
      chk("cross_irq", 32'(alert_irq), 32'd1);
      ack_pulse();

      // hysteresis band holds the alert; ack colliding with the clear-transition loses
      repeat (5) send(12'h4C0);
      chk("hyst_hold", 32'(alert), 32'd1);
      send(12'h4AF);
      send(12'h4AF);
      send(12'h4AF, 1'b1);
      chk("hyst_clear", 32'(alert), 32'd0);
      chk("ack_collide", 32'(alert_irq), 32'd1);
      ack_pulse();
      chk("ack_later", 32'(alert_irq), 32'd0);

      // glitch rejection: the 0x400 restarts the count
      send(12'h510);
      send(12'h510);
      send(12'h400);
      send(12'h510);
      chk("glitch_hold", 32'(alert), 32'd0);
      send(12'h510);
      chk("glitch_cnt2", 32'(alert), 32'd0);
      send(12'h510);
      chk("glitch_cnt3", 32'(alert), 32'd1);
      repeat (3) send(12'h100);
      chk("back_normal", 32'(alert), 32'd0);
      ack_pulse();

      // signed peak tracking
      do_reset();
      chk("peak_rst", 32'(max_temp), 32'h800);
      chk("rst_ignored", 32'(last_temp), 32'h000);
      send(12'hF60);
      chk("peak_neg", 32'(max_temp), 32'hF60);
      send(12'h190);
      chk("peak_pos", 32'(max_temp), 32'h190);
      peak_clr = 1'b1;
      @(posedge clk);
      #1;
      peak_clr = 1'b0;
      m_max    = 12'h800;
      chk("peak_clr", 32'(max_temp), 32'h800);
      send(12'h050, 1'b0, 1'b1);
      chk("peak_clr_coincide", 32'(max_temp), 32'h050);
      send(12'hF00);
      chk("peak_signed", 32'(max_temp), 32'h050);

      // VALID held continuously: one accept every second cycle
      valid = 1'b1;
      data  = 12'h123;
      acc   = 0;
      for (int c = 0; c < 20; c++) begin
         if (ready) begin
            acc++;
            model_sample(12'h123, 1'b0, 1'b0);
         end
         @(posedge clk);
         #1;
      end
      valid = 1'b0;
      chk("throughput", 32'(acc), 32'd10);
      @(posedge clk);
      #1;
      chk("bp_last", 32'(last_temp), 32'(m_last));
      chk("bp_alert", 32'(alert), 32'(m_alert));

      // reset between accept and stage 2 discards the sample
      valid = 1'b1;
      data  = 12'h300;
      @(posedge clk);
      #1;
      valid = 1'b0;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk("midrst_last", 32'(last_temp), 32'h000);
      chk("midrst_max", 32'(max_temp), 32'h800);

`ifdef TEMP_ALERT_WATCHDOG_EN
      do_reset();
      n = 0;
      while (stale !== 1'b1 && n < WD + 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("wd_latency", 32'(n), 32'(WD));
      chk("wd_stale", 32'(stale), 32'd1);
      chk("wd_alert", 32'(alert), 32'd1);
      chk("wd_irq", 32'(alert_irq), 32'd1);
      m_stale = 1'b1;
      m_alert = 1'b1;
      m_irq   = 1'b1;
      ack_pulse();
      send(12'h100);
      chk("wd_clr_stale", 32'(stale), 32'd0);
      chk("wd_clr_alert", 32'(alert), 32'd0);
`else
      repeat (WD + 50) @(posedge clk);
      #1;
      chk("no_wd_stale", 32'(stale), 32'd0);
      chk("no_wd_alert", 32'(alert), 32'(m_alert));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
